// File: rtl/pcs_gray_pkg.sv
// Shared helpers for modulo-N Gray pointers: code mapping, decode search and parameter limits.
// Imported by the pointer counters and their far-domain receivers.
package pcs_gray_pkg;

  localparam int unsigned ModMin        = 2;
  localparam int unsigned ModMax        = 256;
  localparam int unsigned SyncStagesMin = 2;
  localparam int unsigned SyncStagesMax = 4;
  localparam int unsigned CodeWMax      = 8;

  typedef struct packed {
    logic                valid;
    logic [CodeWMax-1:0] bin;
  } dec_t;

  function automatic bit mod_ok(input int unsigned mod);
    return (mod >= ModMin) && (mod <= ModMax) && (mod % 2 == 0);
  endfunction

  function automatic bit sync_ok(input int unsigned stages);
    return (stages >= SyncStagesMin) && (stages <= SyncStagesMax);
  endfunction

  // Upper half is shifted to the top of the 2^w code space so the wrap flips one bit.
  function automatic logic [CodeWMax-1:0] enc(input int unsigned i, input int unsigned mod,
                                             input int unsigned w);
    int unsigned x;
    x = (i < mod / 2) ? i : i + (32'd1 << w) - mod;
    return CodeWMax'(x ^ (x >> 1));
  endfunction

  function automatic dec_t dec(input logic [CodeWMax-1:0] code, input int unsigned mod,
                               input int unsigned w);
    dec_t r;
    r = '0;
    for (int unsigned i = 0; i < ModMax; i++) begin
      if ((i < mod) && !r.valid && (enc(i, mod, w) == code)) begin
        r.valid = 1'b1;
        r.bin   = CodeWMax'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gray_mod_rx.sv
// Far-domain receiver for a modulo-N Gray pointer: synchroniser, registered decode and
// sticky checker for illegal codes or jumps of more than one step.
module gray_mod_rx
  import pcs_gray_pkg::*;
#(
  parameter int unsigned  MOD         = 6,
  parameter int unsigned  SYNC_STAGES = 2,
  localparam int unsigned W           = $clog2(MOD)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] gray_in,
  input  logic         err_clr,
  output logic [W-1:0] rx_bin,
  output logic         rx_err
);

  localparam logic [W-1:0] BinMax = W'(MOD - 1);

  logic [SYNC_STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0]                  rx_bin_q, rx_bin_d, step_bin;
  logic                          rx_err_q, rx_err_d;
  logic                          err;
  dec_t                          dec_r;

  // rx_bin_q is also the previous-value reference for the step check.
  always_comb begin
    dec_r    = dec(CodeWMax'(sync_q[SYNC_STAGES-1]), MOD, W);
    step_bin = (rx_bin_q == BinMax) ? '0 : rx_bin_q + W'(1);
    err      = !dec_r.valid ||
               ((dec_r.bin != CodeWMax'(rx_bin_q)) && (dec_r.bin != CodeWMax'(step_bin)));
    rx_bin_d = dec_r.valid ? W'(dec_r.bin) : rx_bin_q;
    rx_err_d = err | (rx_err_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      rx_bin_q <= '0;
      rx_err_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], gray_in};
      rx_bin_q <= rx_bin_d;
      rx_err_q <= rx_err_d;
    end
  end

  assign rx_bin = rx_bin_q;
  assign rx_err = rx_err_q;

endmodule

// File: rtl/gray_mod_counter.sv
// Modulo-N cyclic Gray counter with registered, glitch-free code output, plus the
// matching receive-side synchroniser/decoder/checker.
module gray_mod_counter
  import pcs_gray_pkg::*;
#(
  parameter int unsigned  MOD         = 6,
  parameter int unsigned  SYNC_STAGES = 2,
  localparam int unsigned W           = $clog2(MOD)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] bin_out,
  output logic [W-1:0] gray_out,
  output logic         wrap,
  input  logic [W-1:0] gray_in,
  output logic [W-1:0] rx_bin,
  output logic         rx_err,
  input  logic         err_clr
);

  if (!mod_ok(MOD)) begin : g_bad_mod
    $error("gray_mod_counter: MOD must be even and within 2..256");
  end
  if (!sync_ok(SYNC_STAGES)) begin : g_bad_sync
    $error("gray_mod_counter: SYNC_STAGES must be within 2..4");
  end

  localparam logic [W-1:0] BinMax = W'(MOD - 1);

  logic [W-1:0] bin_q, bin_d, gray_q, gray_d;
  logic         wrap_q, wrap_d;

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (clr) begin
      bin_d = '0;
    end else if (inc) begin
      if (bin_q == BinMax) begin
        bin_d  = '0;
        wrap_d = 1'b1;
      end else begin
        bin_d = bin_q + W'(1);
      end
    end
    gray_d = W'(enc(32'(bin_d), MOD, W));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;

  gray_mod_rx #(
    .MOD         (MOD),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .gray_in (gray_in),
    .err_clr (err_clr),
    .rx_bin  (rx_bin),
    .rx_err  (rx_err)
  );

`ifdef PCS_SIM
  // clr is a deliberate jump back to zero and may flip several bits.
  gray_one_bit_step: assert property (@(posedge clk) disable iff (reset)
    !$past(clr) |-> ($countones(gray_q ^ $past(gray_q)) <= 1));
`endif

endmodule

// File: tb/tb_gray_mod_counter.sv
// Bench for gray_mod_counter: table-driven counter vectors through a scoreboard queue,
// loopback tracking, reset, illegal-code and jump checks, plus MOD=10 and MOD=2 builds.
module tb_gray_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, inc, clr, err_clr, loop_en;
  logic [2:0] gray_drv, gray_in, bin_out, gray_out, rx_bin;
  logic       wrap, rx_err;

  logic [3:0] bin10, gray10, rx_bin10;
  logic       wrap10, rx_err10;
  logic       bin2, gray2, rx_bin2, wrap2, rx_err2;

  assign gray_in = loop_en ? gray_out : gray_drv;

  gray_mod_counter #(.MOD(6), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .inc(inc), .clr(clr), .bin_out(bin_out), .gray_out(gray_out),
    .wrap(wrap), .gray_in(gray_in), .rx_bin(rx_bin), .rx_err(rx_err), .err_clr(err_clr)
  );

  gray_mod_counter #(.MOD(10), .SYNC_STAGES(3)) u_dut10 (
    .clk(clk), .reset(reset), .inc(inc), .clr(1'b0), .bin_out(bin10), .gray_out(gray10),
    .wrap(wrap10), .gray_in(gray10), .rx_bin(rx_bin10), .rx_err(rx_err10), .err_clr(1'b0)
  );

  gray_mod_counter #(.MOD(2), .SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .reset(reset), .inc(inc), .clr(1'b0), .bin_out(bin2), .gray_out(gray2),
    .wrap(wrap2), .gray_in(gray2), .rx_bin(rx_bin2), .rx_err(rx_err2), .err_clr(1'b0)
  );

  typedef struct {
    logic       inc;
    logic       clr;
    logic [2:0] bin;
    logic [2:0] gray;
    logic       wrap;
  } vec_t;

  vec_t        vecs[$];
  vec_t        sb_q[$];
  int unsigned rx_sb[$];
  int          n_checks = 0;
  int          n_err = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic i, input logic c, input logic [2:0] b, input logic [2:0] g,
                     input logic w);
    vec_t v;
    v.inc = i; v.clr = c; v.bin = b; v.gray = g; v.wrap = w;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    inc = 1'b0; clr = 1'b0; err_clr = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vec_t        e;
    logic [3:0]  prev10;
    logic        prev2;
    int unsigned k;

    reset = 1'b1; inc = 1'b0; clr = 1'b0; err_clr = 1'b0; loop_en = 1'b0; gray_drv = 3'b000;
    #1;
    check("reset bin_out", bin_out, 0);
    check("reset gray_out", gray_out, 0);
    check("reset wrap", wrap, 0);
    check("reset rx_bin", rx_bin, 0);
    check("reset rx_err", rx_err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // {inc, clr} -> {bin_out, gray_out, wrap} after the edge
    add(1, 0, 1, 3'b001, 0); add(1, 0, 2, 3'b011, 0); add(1, 0, 3, 3'b111, 0);
    add(1, 0, 4, 3'b101, 0); add(1, 0, 5, 3'b100, 0); add(1, 0, 0, 3'b000, 1);
    add(1, 0, 1, 3'b001, 0); add(0, 0, 1, 3'b001, 0); add(1, 0, 2, 3'b011, 0);
    add(1, 0, 3, 3'b111, 0); add(1, 1, 0, 3'b000, 0); add(1, 0, 1, 3'b001, 0);
    add(0, 0, 1, 3'b001, 0); add(0, 1, 0, 3'b000, 0); add(0, 1, 0, 3'b000, 0);
    add(1, 0, 1, 3'b001, 0); add(1, 0, 2, 3'b011, 0); add(1, 0, 3, 3'b111, 0);
    add(1, 0, 4, 3'b101, 0); add(1, 0, 5, 3'b100, 0); add(1, 1, 0, 3'b000, 0);
    add(1, 0, 1, 3'b001, 0); add(1, 0, 2, 3'b011, 0); add(1, 0, 3, 3'b111, 0);
    add(1, 0, 4, 3'b101, 0); add(1, 0, 5, 3'b100, 0); add(0, 0, 5, 3'b100, 0);
    add(1, 0, 0, 3'b000, 1); add(0, 0, 0, 3'b000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      inc = vecs[i].inc;
      clr = vecs[i].clr;
      sb_q.push_back(vecs[i]);
      step();
      e = sb_q.pop_front();
      check($sformatf("vec%0d bin_out", i), bin_out, e.bin);
      check($sformatf("vec%0d gray_out", i), gray_out, e.gray);
      check($sformatf("vec%0d wrap", i), wrap, e.wrap);
    end

    // Loopback: rx_bin trails bin_out by three edges
    do_reset();
    loop_en = 1'b1;
    inc = 1'b1;
    prev10 = gray10;
    prev2 = gray2;
    rx_sb.push_back(0); rx_sb.push_back(0); rx_sb.push_back(0);
    for (int j = 1; j <= 20; j++) begin
      k = j;
      step();
      rx_sb.push_back(k % 6);
      check("loop bin_out", bin_out, k % 6);
      check("loop wrap", wrap, (k % 6 == 0) ? 1 : 0);
      check("loop rx_bin", rx_bin, rx_sb.pop_front());
      check("loop rx_err", rx_err, 0);
      check("mod10 one-bit step", $countones(gray10 ^ prev10), 1);
      check("mod10 wrap", wrap10, (k % 10 == 0) ? 1 : 0);
      check("mod2 one-bit step", $countones(gray2 ^ prev2), 1);
      check("mod2 bin_out", bin2, k % 2);
      check("mod2 wrap", wrap2, (k % 2 == 0) ? 1 : 0);
      prev10 = gray10;
      prev2 = gray2;
    end
    check("mod10 rx_bin", rx_bin10, 6);
    check("mod10 rx_err", rx_err10, 0);
    check("mod2 rx_bin", rx_bin2, 1);
    check("mod2 rx_err", rx_err2, 0);

    // Asynchronous reset mid-count, then first inc after release
    reset = 1'b1;
    #1;
    check("async reset bin_out", bin_out, 0);
    check("async reset gray_out", gray_out, 0);
    check("async reset rx_bin", rx_bin, 0);
    step();
    reset = 1'b0;
    step();
    check("post-reset inc bin_out", bin_out, 1);
    check("post-reset inc gray_out", gray_out, 3'b001);

    // Illegal code and multi-step jump on gray_in
    do_reset();
    loop_en = 1'b0;
    gray_drv = 3'b001;
    repeat (3) step();
    check("rx single step bin", rx_bin, 1);
    check("rx single step err", rx_err, 0);

    gray_drv = 3'b010;
    repeat (2) step();
    check("illegal not yet seen", rx_err, 0);
    step();
    check("illegal rx_err", rx_err, 1);
    check("illegal rx_bin held", rx_bin, 1);
    gray_drv = 3'b001;
    repeat (3) step();
    check("rx_err sticky", rx_err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clr clears", rx_err, 0);

    gray_drv = 3'b111;
    repeat (3) step();
    check("jump rx_err", rx_err, 1);
    check("jump rx_bin", rx_bin, 3);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("jump err_clr", rx_err, 0);

    gray_drv = 3'b000;
    repeat (2) step();
    check("jump2 not yet seen", rx_err, 0);
    err_clr = 1'b1;
    step();
    check("error beats err_clr", rx_err, 1);
    check("jump2 rx_bin", rx_bin, 0);
    err_clr = 1'b0;
    step();
    check("jump2 sticky", rx_err, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
